// File: rtl/segre_dcache_tag_assoc.sv
// Set-associative data-cache tag store with true-LRU replacement and an optional flush engine.
// Define SEGRE_DCACHE_TAG_FLUSH_EN to build the flush/write-back FSM; otherwise it is omitted.
module segre_dcache_tag_assoc #(
  parameter int unsigned NUM_WAYS       = 2,
  parameter int unsigned NUM_SETS       = 4,
  parameter int unsigned BYTES_PER_LINE = 16,
  parameter int unsigned ADDR_SIZE      = 32,
  localparam int unsigned WAY_W    = $clog2(NUM_WAYS),
  localparam int unsigned IDX_W    = $clog2(NUM_SETS),
  localparam int unsigned OFF_W    = $clog2(BYTES_PER_LINE),
  localparam int unsigned TAG_SIZE = ADDR_SIZE - IDX_W - OFF_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic [ADDR_SIZE-1:0] addr_i,
  input  logic                 store_i,
  input  logic                 fill_i,
  input  logic [ADDR_SIZE-1:0] fill_addr_i,
  input  logic                 inval_i,
  input  logic [ADDR_SIZE-1:0] inval_addr_i,
  input  logic                 flush_i,
  input  logic                 wb_ack_i,
  output logic                 hit_o,
  output logic                 miss_o,
  output logic [WAY_W-1:0]     hit_way_o,
  output logic [WAY_W-1:0]     victim_way_o,
  output logic                 victim_dirty_o,
  output logic [TAG_SIZE-1:0]  victim_tag_o,
  output logic                 wb_req_o,
  output logic [ADDR_SIZE-1:0] wb_addr_o,
  output logic                 busy_o,
  output logic                 flush_done_o
);

  typedef logic [NUM_WAYS-1:0][WAY_W-1:0] age_vec_t;

  logic [NUM_WAYS-1:0]                valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]                dirty_q [NUM_SETS];
  logic [NUM_WAYS-1:0][TAG_SIZE-1:0]  tag_q   [NUM_SETS];
  age_vec_t                           age_q   [NUM_SETS];

  logic [IDX_W-1:0]    req_idx, fill_idx, inval_idx, flush_idx;
  logic [TAG_SIZE-1:0] req_tag, fill_tag, inval_tag;
  logic [WAY_W-1:0]    req_hit_way, inval_way, fill_way, flush_way;
  logic [NUM_WAYS-1:0] req_match, inval_match;
  logic                fill_en, inval_en, flush_clr;
  logic                unused_offsets;

  assign req_idx   = addr_i[OFF_W +: IDX_W];
  assign fill_idx  = fill_addr_i[OFF_W +: IDX_W];
  assign inval_idx = inval_addr_i[OFF_W +: IDX_W];
  assign req_tag   = addr_i[ADDR_SIZE-1 -: TAG_SIZE];
  assign fill_tag  = fill_addr_i[ADDR_SIZE-1 -: TAG_SIZE];
  assign inval_tag = inval_addr_i[ADDR_SIZE-1 -: TAG_SIZE];
  assign unused_offsets = ^{addr_i[OFF_W-1:0], fill_addr_i[OFF_W-1:0], inval_addr_i[OFF_W-1:0]};

  // Lowest invalid way first; otherwise the least recently used (maximum age) way.
  function automatic logic [WAY_W-1:0] pick_victim(input logic [NUM_WAYS-1:0] valid,
                                                   input age_vec_t age);
    logic [WAY_W-1:0] v;
    logic             found;
    v     = '0;
    found = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found && !valid[w]) begin
        v     = WAY_W'(w);
        found = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (age[w] == WAY_W'(NUM_WAYS - 1)) v = WAY_W'(w);
      end
    end
    return v;
  endfunction

  function automatic age_vec_t touch(input age_vec_t age, input logic [WAY_W-1:0] way);
    age_vec_t n;
    n = age;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (age[w] < age[way]) n[w] = age[w] + 1'b1;
    end
    n[way] = '0;
    return n;
  endfunction

  always_comb begin
    req_match   = '0;
    inval_match = '0;
    req_hit_way = '0;
    inval_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      req_match[w]   = valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag);
      inval_match[w] = valid_q[inval_idx][w] && (tag_q[inval_idx][w] == inval_tag);
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (req_match[w])   req_hit_way = WAY_W'(w);
      if (inval_match[w]) inval_way   = WAY_W'(w);
    end
  end

  assign hit_o          = req_i & ~busy_o & (|req_match);
  assign miss_o         = req_i & ~busy_o & ~(|req_match);
  assign hit_way_o      = hit_o ? req_hit_way : '0;
  assign victim_way_o   = pick_victim(valid_q[req_idx], age_q[req_idx]);
  assign victim_dirty_o = dirty_q[req_idx][victim_way_o];
  assign victim_tag_o   = tag_q[req_idx][victim_way_o];

  assign fill_way = pick_victim(valid_q[fill_idx], age_q[fill_idx]);
  assign fill_en  = fill_i & ~busy_o;
  assign inval_en = inval_i & ~busy_o & (|inval_match);

  // Later assignments take priority: fill beats inval beats the store-hit dirty update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        tag_q[s]   <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
    end else begin
      if (hit_o) begin
        if (store_i) dirty_q[req_idx][req_hit_way] <= 1'b1;
        if (!(fill_en && fill_idx == req_idx)) begin
          age_q[req_idx] <= touch(age_q[req_idx], req_hit_way);
        end
      end
      if (inval_en) begin
        valid_q[inval_idx][inval_way] <= 1'b0;
        dirty_q[inval_idx][inval_way] <= 1'b0;
      end
      if (fill_en) begin
        valid_q[fill_idx][fill_way] <= 1'b1;
        dirty_q[fill_idx][fill_way] <= store_i;
        tag_q[fill_idx][fill_way]   <= fill_tag;
        age_q[fill_idx]             <= touch(age_q[fill_idx], fill_way);
      end
      if (flush_clr) begin
        valid_q[flush_idx][flush_way] <= 1'b0;
        dirty_q[flush_idx][flush_way] <= 1'b0;
      end
    end
  end

`ifdef SEGRE_DCACHE_TAG_FLUSH_EN
  typedef enum logic [1:0] {StIdle, StScan, StWb, StDone} flush_state_e;

  flush_state_e           state_q;
  logic [IDX_W+WAY_W-1:0] cnt_q;
  logic                   busy_q, wb_req_q, done_q;
  logic [ADDR_SIZE-1:0]   wb_addr_q;
  logic                   cur_dirty, cnt_last;

  assign flush_idx = cnt_q[WAY_W +: IDX_W];
  assign flush_way = cnt_q[WAY_W-1:0];
  assign cur_dirty = valid_q[flush_idx][flush_way] & dirty_q[flush_idx][flush_way];
  assign cnt_last  = &cnt_q;
  assign flush_clr = ((state_q == StScan) && !cur_dirty) || ((state_q == StWb) && wb_ack_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      wb_req_q  <= 1'b0;
      done_q    <= 1'b0;
      wb_addr_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (flush_i) begin
            state_q <= StScan;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StScan: begin
          if (cur_dirty) begin
            state_q   <= StWb;
            wb_req_q  <= 1'b1;
            wb_addr_q <= {tag_q[flush_idx][flush_way], flush_idx, {OFF_W{1'b0}}};
          end else if (cnt_last) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWb: begin
          if (wb_ack_i) begin
            wb_req_q  <= 1'b0;
            wb_addr_q <= '0;
            if (cnt_last) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StScan;
              cnt_q   <= cnt_q + 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign wb_req_o     = wb_req_q;
  assign wb_addr_o    = wb_addr_q;
  assign flush_done_o = done_q;
`else
  logic unused_flush;
  assign unused_flush = flush_i ^ wb_ack_i;
  assign flush_idx    = '0;
  assign flush_way    = '0;
  assign flush_clr    = 1'b0;
  assign busy_o       = 1'b0;
  assign wb_req_o     = 1'b0;
  assign wb_addr_o    = '0;
  assign flush_done_o = 1'b0;
`endif

endmodule

// File: tb/tb_segre_dcache_tag_assoc.sv
// Self-checking bench for segre_dcache_tag_assoc: directed scenarios plus random traffic
// checked against a timestamp-based LRU reference model.
module tb_segre_dcache_tag_assoc;
  localparam int NW = 2, NS = 4, BPL = 16, AW = 32;
  localparam int TW = AW - 6;

  logic          clk = 1'b0;
  logic          rst, req, store, fill, inval, flush, wb_ack;
  logic [AW-1:0] addr, fill_addr, inval_addr;
  logic          hit, miss, victim_dirty, wb_req, busy, flush_done;
  logic [0:0]    hit_way, victim_way;
  logic [TW-1:0] victim_tag;
  logic [AW-1:0] wb_addr;

  int nchk = 0, nfail = 0;

  always #5 clk = ~clk;

  segre_dcache_tag_assoc #(
    .NUM_WAYS(NW), .NUM_SETS(NS), .BYTES_PER_LINE(BPL), .ADDR_SIZE(AW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .store_i(store),
    .fill_i(fill), .fill_addr_i(fill_addr), .inval_i(inval), .inval_addr_i(inval_addr),
    .flush_i(flush), .wb_ack_i(wb_ack), .hit_o(hit), .miss_o(miss), .hit_way_o(hit_way),
    .victim_way_o(victim_way), .victim_dirty_o(victim_dirty), .victim_tag_o(victim_tag),
    .wb_req_o(wb_req), .wb_addr_o(wb_addr), .busy_o(busy), .flush_done_o(flush_done)
  );

  // Reference model: recency tracked as last-use timestamps; smallest stamp = LRU.
  bit          m_valid[NS][NW];
  bit          m_dirty[NS][NW];
  int unsigned m_tag[NS][NW];
  int          m_stamp[NS][NW];
  int          m_now;

  function automatic int m_set(input logic [AW-1:0] a);
    int unsigned ua = a;
    return int'((ua / BPL) % NS);
  endfunction

  function automatic int unsigned m_tagof(input logic [AW-1:0] a);
    int unsigned ua = a;
    return ua / (BPL * NS);
  endfunction

  task automatic m_lookup(input logic [AW-1:0] a, output bit h, output int way);
    int s = m_set(a);
    h = 0;
    way = 0;
    for (int w = NW - 1; w >= 0; w--) begin
      if (m_valid[s][w] && m_tag[s][w] == m_tagof(a)) begin
        h = 1;
        way = w;
      end
    end
  endtask

  function automatic int m_victim(input int s);
    int best = 0;
    for (int w = 0; w < NW; w++) if (!m_valid[s][w]) return w;
    for (int w = 1; w < NW; w++) if (m_stamp[s][w] < m_stamp[s][best]) best = w;
    return best;
  endfunction

  task automatic m_reset();
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < NW; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
        m_tag[s][w]   = 0;
        m_stamp[s][w] = -w;
      end
    end
    m_now = 0;
  endtask

  task automatic m_commit();
    bit h, ih;
    int hw, iw, s, fs, fv, is;
    s  = m_set(addr);
    fs = m_set(fill_addr);
    is = m_set(inval_addr);
    m_lookup(addr, h, hw);
    m_lookup(inval_addr, ih, iw);
    fv = m_victim(fs);
    m_now++;
    if (req && h) begin
      if (store) m_dirty[s][hw] = 1;
      if (!(fill && fs == s)) m_stamp[s][hw] = m_now;
    end
    if (inval && ih) begin
      m_valid[is][iw] = 0;
      m_dirty[is][iw] = 0;
    end
    if (fill) begin
      m_valid[fs][fv] = 1;
      m_dirty[fs][fv] = store;
      m_tag[fs][fv]   = m_tagof(fill_addr);
      m_stamp[fs][fv] = m_now;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_lookup();
    bit h;
    int w, s, v;
    s = m_set(addr);
    m_lookup(addr, h, w);
    v = m_victim(s);
    check("hit", hit, 64'(req && h));
    check("miss", miss, 64'(req && !h));
    check("hit_way", hit_way, (req && h) ? 64'(w) : 64'd0);
    check("victim_way", victim_way, 64'(v));
    check("victim_dirty", victim_dirty, 64'(m_dirty[s][v]));
    check("victim_tag", victim_tag, 64'(m_tag[s][v]));
    check("idle_busy", busy, 0);
  endtask

  // Inputs must already be applied; compare mid-cycle, then advance one edge.
  task automatic cycle();
    #1;
    check_lookup();
    m_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req = 0; store = 0; fill = 0; inval = 0; flush = 0; wb_ack = 0;
    addr = 0; fill_addr = 0; inval_addr = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    @(posedge clk);
    #1;
    check("rst_hit", hit, 0);
    check("rst_miss", miss, 0);
    check("rst_victim_way", victim_way, 0);
    check("rst_victim_dirty", victim_dirty, 0);
    check("rst_victim_tag", victim_tag, 0);
    check("rst_busy", busy, 0);
    check("rst_wb_req", wb_req, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_done", flush_done, 0);
    rst = 0;
    m_reset();
  endtask

  task automatic do_fill(input logic [AW-1:0] a, input logic st);
    clear_inputs();
    fill = 1; fill_addr = a; addr = a; store = st;
    cycle();
    clear_inputs();
  endtask

  task automatic do_req(input logic [AW-1:0] a, input logic st);
    clear_inputs();
    req = 1; addr = a; store = st;
    cycle();
    clear_inputs();
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    int unsigned t = $urandom_range(0, 3), s = $urandom_range(0, NS - 1);
    int unsigned o = $urandom_range(0, BPL - 1);
    return AW'((t * NS + s) * BPL + o);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned exp_wb[$];
    int k, done_cnt, hold;
    bit fin;

    do_reset();

    // Cold miss, fill, then hit on another offset of the same line.
    clear_inputs(); req = 1; addr = 32'h100; #1;
    check("r45_miss", miss, 1);
    check("r45_victim", victim_way, 0);
    cycle();
    do_fill(32'h100, 0);
    clear_inputs(); req = 1; addr = 32'h104; #1;
    check("r45_hit", hit, 1);
    check("r45_hit_way", hit_way, 0);
    cycle();

    // LRU replacement within set 0.
    do_reset();
    do_fill(32'h100, 0);
    do_fill(32'h200, 0);
    do_req(32'h100, 0);
    addr = 32'h100; #1;
    check("r46_victim", victim_way, 1);
    cycle();
    clear_inputs(); fill = 1; fill_addr = 32'h300; addr = 32'h300; #1;
    check("r46_fill_victim", victim_way, 1);
    cycle();
    clear_inputs(); req = 1; addr = 32'h200; #1;
    check("r46_evicted_miss", miss, 1);
    cycle();
    do_req(32'h300, 0);

    // Dirty victim reporting.
    do_reset();
    do_fill(32'h100, 0);
    do_req(32'h100, 1);
    do_fill(32'h200, 0);
    clear_inputs(); fill = 1; fill_addr = 32'h300; addr = 32'h300; #1;
    check("r47_victim_dirty", victim_dirty, 1);
    check("r47_victim_tag", victim_tag, 64'(32'h100 >> 6));
    cycle();

    // Same-cycle inval and fill in one set.
    do_reset();
    do_fill(32'h100, 0);
    clear_inputs();
    inval = 1; inval_addr = 32'h100; fill = 1; fill_addr = 32'h140; addr = 32'h140;
    cycle();
    clear_inputs(); req = 1; addr = 32'h100; #1;
    check("r48_inval_miss", miss, 1);
    cycle();
    do_req(32'h140, 0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      req        = 1'($urandom_range(0, 1));
      store      = 1'($urandom_range(0, 2) == 0);
      addr       = rnd_addr();
      fill       = 1'($urandom_range(0, 3) == 0);
      fill_addr  = rnd_addr();
      inval      = 1'($urandom_range(0, 5) == 0);
      inval_addr = rnd_addr();
      cycle();
    end
    clear_inputs();

`ifdef SEGRE_DCACHE_TAG_FLUSH_EN
    // Flush with two dirty lines and one clean line.
    do_reset();
    do_fill(32'h100, 1);
    do_fill(32'h300, 0);
    do_fill(32'h210, 1);
    exp_wb = {};
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++)
        if (m_valid[s][w] && m_dirty[s][w]) exp_wb.push_back((m_tag[s][w] * NS + s) * BPL);
    flush = 1;
    @(posedge clk); #1;
    flush = 0; req = 1; addr = 32'h100;
    #1;
    check("flush_busy", busy, 1);
    k = 0; done_cnt = 0; hold = 0; fin = 0;
    for (int c = 0; c < 100 && !fin; c++) begin
      if (busy) begin
        check("busy_hit", hit, 0);
        check("busy_miss", miss, 0);
      end
      if (hold > 0) check("wb_held", wb_req, 1);
      if (flush_done) done_cnt++;
      if (wb_req) begin
        if (k < exp_wb.size()) check("wb_addr", wb_addr, 64'(exp_wb[k]));
        else check("wb_extra", wb_req, 0);
        hold++;
        wb_ack = (hold == 3);
        if (hold == 3) begin
          hold = 0;
          k++;
        end
      end else begin
        wb_ack = 0;
      end
      if (!busy && c > 0) fin = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("flush_finished", 64'(fin), 1);
    check("wb_count", 64'(k), 64'(exp_wb.size()));
    check("done_pulses", 64'(done_cnt), 1);
    check("done_low", flush_done, 0);
    clear_inputs();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
      end
    clear_inputs(); req = 1; addr = 32'h100; #1;
    check("post_flush_miss", miss, 1);
    cycle();
    do_req(32'h210, 0);
    do_req(32'h300, 0);

    // Reset while a write-back is pending.
    do_reset();
    do_fill(32'h100, 1);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    fin = 0;
    for (int c = 0; c < 10 && !fin; c++) begin
      if (wb_req) fin = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("r50_reached_wb", 64'(fin), 1);
    rst = 1;
    @(posedge clk); #1;
    check("r50_busy", busy, 0);
    check("r50_wb_req", wb_req, 0);
    rst = 0;
    m_reset();
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (flush_done) done_cnt++;
      @(posedge clk); #1;
    end
    check("r50_no_done", 64'(done_cnt), 0);
    check("r50_idle", busy, 0);
    do_req(32'h100, 0);
`else
    // Without the flush engine, flush and write-back ack have no effect.
    do_reset();
    do_fill(32'h100, 1);
    clear_inputs(); flush = 1; wb_ack = 1;
    cycle();
    clear_inputs();
    check("noflush_busy", busy, 0);
    check("noflush_wb_req", wb_req, 0);
    check("noflush_wb_addr", wb_addr, 0);
    check("noflush_done", flush_done, 0);
    clear_inputs(); req = 1; addr = 32'h100; #1;
    check("noflush_still_hit", hit, 1);
    cycle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/segre_dcache_tag_assoc.md
SEGRE_DCACHE_TAG_ASSOC -- requirements
Module: segre_dcache_tag_assoc

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 2, number of ways per set, a power of two and at least 2.
REQ-002 SHALL have parameter NUM_SETS, default 4, number of sets, a power of two and at least 2.
REQ-003 SHALL have parameter BYTES_PER_LINE, default 16, line size in bytes, a power of two.
REQ-004 SHALL have parameter ADDR_SIZE, default 32, address width.
REQ-005 SHALL have port clk_i  in  1  clock; one clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i  in  1  reset; synchronous, active-high.
REQ-007 SHALL have port req_i  in  1  lookup request.
REQ-008 SHALL have port addr_i  in  ADDR_SIZE  lookup address.
REQ-009 SHALL have port store_i  in  1  the lookup is a store; a hit marks the line dirty.
REQ-010 SHALL have port fill_i  in  1  install line fill_addr_i into way victim_way_o.
REQ-011 SHALL have port fill_addr_i  in  ADDR_SIZE  fill address.
REQ-012 SHALL have port inval_i  in  1  invalidate the line matching inval_addr_i.
REQ-013 SHALL have port inval_addr_i  in  ADDR_SIZE  invalidate address.
REQ-014 SHALL have port flush_i  in  1  start a flush (pulse).
REQ-015 SHALL have port wb_ack_i  in  1  write-back accepted.
REQ-016 SHALL have ports hit_o, miss_o  out  1 each  lookup result.
REQ-017 SHALL have port hit_way_o  out  log2(NUM_WAYS)  way that hit.
REQ-018 SHALL have ports victim_way_o (log2 NUM_WAYS), victim_dirty_o (1) and victim_tag_o (TAG_SIZE), all out: replacement candidate for the addr_i set.
REQ-019 SHALL have ports wb_req_o (1) and wb_addr_o (ADDR_SIZE, line-aligned), both out: flush write-back request.
REQ-020 SHALL have ports busy_o (1) and flush_done_o (1), both out: flush in progress; one-cycle completion pulse.

Function
REQ-021 SHALL split addresses as offset = low log2(BYTES_PER_LINE) bits, index = next log2(NUM_SETS) bits, tag = remaining TAG_SIZE bits.
REQ-022 SHALL, per set and way, hold valid, dirty, the tag and an age counter of log2(NUM_WAYS) bits.
REQ-023 SHALL compute hit_o as req_i & ~busy_o & (some valid way of the set has a matching tag), combinationally in the same cycle.
REQ-024 SHALL compute miss_o as req_i & ~busy_o & ~hit.
REQ-025 SHALL drive hit_way_o to 0 when there is no hit.
REQ-026 SHALL select as victim the lowest-index invalid way; if all ways are valid, the way with maximum age; victim_dirty_o and victim_tag_o describe that way.
REQ-027 SHALL apply an LRU touch on a hit or a fill of way w: age[w] becomes 0, and every way of the set with age below the old age[w] increments; the ages of a set always remain a permutation.
REQ-028 SHALL, on a store hit, set the dirty bit of the hit way at the next edge.
REQ-029 SHALL, on fill_i, write tag, valid=1 and dirty=store_i into victim_way_o of the fill_addr_i set, and touch that way.
REQ-030 SHALL, on inval_i, clear valid and dirty of the matching way; with no match it has no effect.
REQ-031 SHALL, when a request and a fill/inval occur in the same cycle, return the lookup on the pre-update state.
REQ-032 SHALL, when inval_i and fill_i target the same set and way in one cycle, let the fill win.
REQ-033 SHALL, when fill and hit touch the same set in one cycle, let the fill's touch win.
REQ-034 SHALL implement a flush FSM with states IDLE, SCAN, WB and DONE.
REQ-035 SHALL move IDLE->SCAN on flush_i, with a set/way counter at 0 and busy_o high.
REQ-036 SHALL, in SCAN, visit one entry per cycle; a valid dirty entry goes to WB, otherwise the entry is cleared and the counter advances.
REQ-037 SHALL, in WB, hold wb_req_o high and wb_addr_o = {tag, index, 0} stable until wb_ack_i, then clear the entry, advance and return to SCAN.
REQ-038 SHALL, after the last entry, pass through DONE for exactly one cycle with flush_done_o=1, then go to IDLE with busy_o low.
REQ-039 SHALL ignore req_i, fill_i, inval_i and flush_i while busy_o is high.
REQ-040 SHALL end a flush with all entries invalid and all ages unchanged.

Reset
REQ-041 SHALL, on rst_i, clear all valid and dirty bits, set age[w]=w in every set and put the FSM in IDLE.
REQ-042 SHALL hold all outputs at 0 during and after reset until stimulus, including when reset arrives mid-flush, which aborts the flush with no flush_done_o.

Configuration
REQ-043 SHALL, with SEGRE_DCACHE_TAG_FLUSH_EN defined, include the flush FSM as specified.
REQ-044 SHALL, without SEGRE_DCACHE_TAG_FLUSH_EN, omit the FSM: flush_i and wb_ack_i are ignored and busy_o, wb_req_o, wb_addr_o and flush_done_o are tied to 0.

Verification (NUM_WAYS=2, NUM_SETS=4, BYTES_PER_LINE=16)
REQ-045 SHALL cover: after reset, req addr 0x100 -> miss_o=1, victim_way_o=0; fill 0x100; req 0x104 -> hit_o=1, hit_way_o=0.
REQ-046 SHALL cover: fill 0x100 then 0x200 (set 0); req 0x100 -> victim_way_o=1; fill 0x300 replaces way 1; req 0x200 -> miss_o=1.
REQ-047 SHALL cover: store hit on 0x100, then fill two new set-0 lines -> on the second fill victim_dirty_o=1, victim_tag_o=0x100>>6.
REQ-048 SHALL cover: inval 0x100 and fill 0x140 in the same cycle -> inval has its effect, fill installs; req 0x100 -> miss_o=1.
REQ-049 SHALL cover: two dirty lines 0x100 and 0x210; flush_i -> wb_req_o with wb_addr_o 0x100 held 3 cycles until ack, then 0x210; flush_done_o pulses once; all lookups then miss.
REQ-050 SHALL cover: rst_i asserted during WB -> busy_o=0 and wb_req_o=0 next cycle, and flush_done_o never asserts.
